hash_absorb_packer: RTL and testbench

Collects the 64-bit, byte-reordered lanes produced by the public-key/message hash lane former and assembles them into full Keccak rate blocks for the sponge permutation core. Applies SHA3/SHAKE multi-rate padding at end of message and hands each block to the permutation through a valid/ready handshake. Sits between the lane former and the Keccak-f[1600] absorb port.

---
 rtl/hash_absorb_packer.sv | 140 ++++++++++++++
 tb/tb_hash_absorb_packer.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/hash_absorb_packer.sv
// Packs 64-bit Keccak lanes into RATE_LANES-wide rate blocks, applies SHA3/SHAKE
// multi-rate padding at end of message and offers each block over valid/ready.
module hash_absorb_packer #(
  parameter int          RATE_LANES = 17,
  parameter logic [7:0]  DS_BYTE    = 8'h06
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       lane_in_valid,
  input  logic [63:0]                lane_in_data,
  input  logic                       lane_in_last,
  output logic                       lane_in_ready,
  output logic                       blk_valid,
  output logic [64*RATE_LANES-1:0]   blk_data,
  output logic                       blk_first,
  output logic                       blk_last,
  input  logic                       blk_ready,
  output logic [4:0]                 lane_cnt,
  output logic                       msg_done
);

  typedef enum logic [1:0] {FILL, PAD, OUT, OUT_PAD} state_t;

  localparam logic [4:0] LAST_IDX = 5'(RATE_LANES - 1);

  state_t     state_reg, state_next;
  logic [4:0] lane_cnt_reg, lane_cnt_next;
  logic       first_reg, first_next;
  logic       last_reg, last_next;
  logic       pad_pending_reg, pad_pending_next;
  logic       done_reg, done_next;
  logic       wr_en;
  logic       pad_en;

  always_comb begin
    state_next       = state_reg;
    lane_cnt_next    = lane_cnt_reg;
    first_next       = first_reg;
    last_next        = last_reg;
    pad_pending_next = pad_pending_reg;
    done_next        = 1'b0;
    wr_en            = 1'b0;
    pad_en           = 1'b0;
    case (state_reg)
      FILL: begin
        if (lane_in_valid) begin
          wr_en         = 1'b1;
          lane_cnt_next = lane_cnt_reg + 5'd1;
          if (lane_cnt_reg == LAST_IDX) begin
            state_next       = OUT;
            last_next        = 1'b0;
            pad_pending_next = lane_in_last;
          end else if (lane_in_last) begin
            state_next = PAD;
          end
        end
      end
      // OUT_PAD runs with lane_cnt already 0, so the same rule yields a pad-only block.
      PAD, OUT_PAD: begin
        pad_en           = 1'b1;
        last_next        = 1'b1;
        pad_pending_next = 1'b0;
        state_next       = OUT;
      end
      OUT: begin
        if (blk_ready) begin
          lane_cnt_next = 5'd0;
          first_next    = 1'b0;
          last_next     = 1'b0;
          if (last_reg) begin
            done_next  = 1'b1;
            first_next = 1'b1;
            state_next = FILL;
          end else if (pad_pending_reg) begin
            state_next = OUT_PAD;
          end else begin
            state_next = FILL;
          end
        end
      end
      default: state_next = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= FILL;
      lane_cnt_reg    <= 5'd0;
      first_reg       <= 1'b1;
      last_reg        <= 1'b0;
      pad_pending_reg <= 1'b0;
      done_reg        <= 1'b0;
    end else begin
      state_reg       <= state_next;
      lane_cnt_reg    <= lane_cnt_next;
      first_reg       <= first_next;
      last_reg        <= last_next;
      pad_pending_reg <= pad_pending_next;
      done_reg        <= done_next;
    end
  end

  // One register per slot; the pad value merges DS byte, zero fill and the final 0x80.
  for (genvar gi = 0; gi < RATE_LANES; gi++) begin : g_slot
    logic [63:0] slot_reg;
    logic [63:0] pad_lane;

    always_comb begin
      pad_lane = slot_reg;
      if (5'(gi) == lane_cnt_reg) begin
        pad_lane = {56'd0, DS_BYTE};
      end else if (5'(gi) > lane_cnt_reg) begin
        pad_lane = 64'd0;
      end
      if (gi == RATE_LANES - 1) begin
        pad_lane[63:56] = pad_lane[63:56] | 8'h80;
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        slot_reg <= 64'd0;
      end else if (wr_en && (lane_cnt_reg == 5'(gi))) begin
        slot_reg <= lane_in_data;
      end else if (pad_en) begin
        slot_reg <= pad_lane;
      end
    end

    assign blk_data[64*gi +: 64] = slot_reg;
  end

  assign lane_in_ready = (state_reg == FILL);
  assign blk_valid     = (state_reg == OUT);
  assign blk_first     = first_reg;
  assign blk_last      = last_reg;
  assign lane_cnt      = lane_cnt_reg;
  assign msg_done      = done_reg;

endmodule

// File: tb/tb_hash_absorb_packer.sv
// Randomized bench for hash_absorb_packer: messages are padded by a simple
// Keccak pad10*1 model and the resulting blocks compared against the DUT.
module tb_hash_absorb_packer;
  localparam int R = 17;
  localparam logic [7:0] DS = 8'h06;
  localparam int W = 64 * R;

  logic         clk = 1'b0;
  logic         rst;
  logic         lane_in_valid;
  logic [63:0]  lane_in_data;
  logic         lane_in_last;
  logic         lane_in_ready;
  logic         blk_valid;
  logic [W-1:0] blk_data;
  logic         blk_first;
  logic         blk_last;
  logic         blk_ready;
  logic [4:0]   lane_cnt;
  logic         msg_done;

  int total = 0;
  int bad   = 0;

  logic [63:0]  msg [0:127];
  logic [63:0]  padv [0:255];
  logic [W-1:0] exp_blk [0:7];

  hash_absorb_packer #(.RATE_LANES(R), .DS_BYTE(DS)) dut (
    .clk(clk), .rst(rst),
    .lane_in_valid(lane_in_valid), .lane_in_data(lane_in_data),
    .lane_in_last(lane_in_last), .lane_in_ready(lane_in_ready),
    .blk_valid(blk_valid), .blk_data(blk_data), .blk_first(blk_first),
    .blk_last(blk_last), .blk_ready(blk_ready), .lane_cnt(lane_cnt),
    .msg_done(msg_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, want);
    end
  endtask

  // Message lanes, then zeros; DS XORed at position n and 0x80 into the top byte of the last lane.
  task automatic build_expected(input int n, output int nb);
    nb = n / R + 1;
    for (int i = 0; i < nb * R; i++) padv[i] = (i < n) ? msg[i] : 64'd0;
    padv[n] = padv[n] ^ {56'd0, DS};
    padv[nb*R-1] = padv[nb*R-1] ^ 64'h8000_0000_0000_0000;
    for (int j = 0; j < nb; j++)
      for (int s = 0; s < R; s++) exp_blk[j][64*s +: 64] = padv[j*R + s];
  endtask

  task automatic run_msg(input int n, input int hold, input string name);
    int nb, idx, bi, waitc, evt, lat;
    bit seen, pend, done_exp, finished;
    build_expected(n, nb);
    idx = 0; bi = 0; waitc = 0; evt = 0; lat = 0;
    seen = 0; pend = 0; done_exp = 0; finished = 0;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      check({name, ":msg_done"}, W'(msg_done), W'(done_exp));
      done_exp = 0;
      if (bi == nb) begin
        finished = 1;
        break;
      end
      blk_ready = 1'b0;
      if (blk_valid) begin
        if (!seen) check({name, ":latency"}, W'(c - evt), W'(lat));
        seen = 1;
        check({name, ":blk_data"}, blk_data, exp_blk[bi]);
        check({name, ":blk_first"}, W'(blk_first), W'(bi == 0));
        check({name, ":blk_last"}, W'(blk_last), W'(bi == nb - 1));
        check({name, ":ready_in_out"}, W'(lane_in_ready), W'(0));
        blk_ready = (waitc >= hold);
        waitc++;
        if (blk_ready) begin
          $display("block %0d of %s accepted (first=%0b last=%0b)", bi, name, blk_first, blk_last);
          bi++; seen = 0; waitc = 0; evt = c; lat = 2;
          done_exp = (bi == nb);
        end
      end else begin
        blk_ready = 1'($urandom % 2);
      end
      if (!pend && idx < n) pend = ($urandom % 4 != 0);
      lane_in_valid = pend;
      lane_in_data  = pend ? msg[idx] : 64'({$urandom, $urandom});
      lane_in_last  = pend && (idx == n - 1);
      if (pend && lane_in_ready) begin
        idx++; pend = 0; evt = c;
        lat = (idx % R == 0) ? 1 : ((idx == n) ? 2 : 0);
      end
    end
    lane_in_valid = 1'b0; lane_in_last = 1'b0; blk_ready = 1'b0;
    if (!finished) begin
      total++; bad++;
      $display("FAIL %s:timeout got=%0d blocks exp=%0d", name, bi, nb);
    end
    $display("message %s: %0d lanes, %0d blocks expected", name, n, nb);
  endtask

  task automatic rand_msg(input int n);
    for (int i = 0; i < n; i++) msg[i] = {$urandom, $urandom};
  endtask

  initial begin
    rst = 1'b1; lane_in_valid = 1'b0; lane_in_data = 64'd0;
    lane_in_last = 1'b0; blk_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    check("rst:blk_valid", W'(blk_valid), W'(0));
    check("rst:lane_in_ready", W'(lane_in_ready), W'(1));
    check("rst:blk_first", W'(blk_first), W'(1));
    check("rst:blk_last", W'(blk_last), W'(0));
    check("rst:lane_cnt", W'(lane_cnt), W'(0));
    check("rst:msg_done", W'(msg_done), W'(0));
    check("rst:blk_data", blk_data, W'(0));
    $display("reset state checked");

    for (int i = 0; i < 5; i++) msg[i] = 64'(i + 1);
    run_msg(5, 0, "five");
    rand_msg(16); run_msg(16, 1, "sixteen");
    rand_msg(17); run_msg(17, 0, "seventeen");
    rand_msg(40); run_msg(40, 10, "forty");

    // Reset in the middle of a block, then a short message must start fresh.
    rand_msg(9);
    for (int i = 0; i < 9; i++) begin
      lane_in_valid = 1'b1; lane_in_data = msg[i]; lane_in_last = 1'b0;
      @(negedge clk);
    end
    lane_in_valid = 1'b0;
    check("mid:lane_cnt_before", W'(lane_cnt), W'(9));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid:lane_cnt", W'(lane_cnt), W'(0));
    check("mid:blk_valid", W'(blk_valid), W'(0));
    check("mid:blk_first", W'(blk_first), W'(1));
    check("mid:msg_done", W'(msg_done), W'(0));
    $display("mid-block reset checked");
    rand_msg(3); run_msg(3, 2, "after_rst");

    for (int k = 0; k < 6; k++) begin
      int n;
      n = $urandom_range(1, 60);
      rand_msg(n);
      run_msg(n, $urandom_range(0, 3), "random");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
